// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, VGA write-port widths and the fill-engine state encoding
// shared by rect_fill_engine and future drawing engines.
package vga_pkg;
   localparam int SCREEN_W    = 160;
   localparam int SCREEN_H    = 120;
   localparam int VGA_ADDR_W  = 15;
   localparam int VGA_COLOR_W = 3;
   typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} fill_state_t;
endpackage

// File: rtl/pixel_pacer.sv
// pixel_pacer: one-cycle write_enable pulse followed by GAP_CYCLES low cycles,
// strobing advance on the last gap cycle so the owner can step to the next pixel.
module pixel_pacer #(
   parameter int GAP_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pulse,
   input  logic i_gap,
   output logic o_write_enable,
   output logic o_advance
);
   localparam int W = $clog2(GAP_CYCLES + 1);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk)
      if (rst) r_cnt <= '0;
      else if (i_pulse) r_cnt <= W'(GAP_CYCLES - 1);
      else if (i_gap && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_write_enable = i_pulse;
   assign o_advance      = i_gap && r_cnt == '0;
endmodule

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: turns one fill-rectangle command into paced single-pixel VGA writes.
// Define RECT_CLIP_EN to clamp off-screen corners instead of dropping the command.
module rect_fill_engine
   import vga_pkg::*;
#(
   parameter int GAP_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [7:0]             cmd_x0,
   input  logic [7:0]             cmd_x1,
   input  logic [6:0]             cmd_y0,
   input  logic [6:0]             cmd_y1,
   input  logic [VGA_COLOR_W-1:0] cmd_color,
   output logic                   cmd_err,
   output logic                   busy,
   output logic [VGA_ADDR_W-1:0]  data_addr,
   output logic [VGA_COLOR_W-1:0] data_in,
   output logic                   write_enable
);
   fill_state_t            r_state;
   logic                   r_ready, r_err;
   logic [7:0]             r_x, r_xmin, r_xmax;
   logic [6:0]             r_y, r_ymax;
   logic [VGA_ADDR_W-1:0]  r_row, r_addr;
   logic [VGA_COLOR_W-1:0] r_color;
   logic [7:0]             w_xlo, w_xtop, w_xhi;
   logic [6:0]             w_ylo, w_ytop, w_yhi;
   logic [VGA_ADDR_W-1:0]  w_row;
   logic                   w_drop, w_adv;

   // Raw corners sit in r_xmin/r_xmax/r_y/r_ymax until SETUP normalises them in place.
   always_comb begin
      w_xlo  = r_xmin > r_xmax ? r_xmax : r_xmin;
      w_xtop = r_xmin > r_xmax ? r_xmin : r_xmax;
      w_ylo  = r_y > r_ymax ? r_ymax : r_y;
      w_ytop = r_y > r_ymax ? r_y : r_ymax;
`ifdef RECT_CLIP_EN
      w_drop = w_xlo >= 8'(SCREEN_W) || w_ylo >= 7'(SCREEN_H);
      w_xhi  = w_xtop >= 8'(SCREEN_W) ? 8'(SCREEN_W - 1) : w_xtop;
      w_yhi  = w_ytop >= 7'(SCREEN_H) ? 7'(SCREEN_H - 1) : w_ytop;
`else
      w_drop = w_xtop >= 8'(SCREEN_W) || w_ytop >= 7'(SCREEN_H);
      w_xhi  = w_xtop;
      w_yhi  = w_ytop;
`endif
      w_row  = (VGA_ADDR_W'(w_ylo) << 7) + (VGA_ADDR_W'(w_ylo) << 5);
   end

   always_ff @(posedge clk)
      if (rst) begin
         r_state <= IDLE;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_x     <= '0;
         r_xmin  <= '0;
         r_xmax  <= '0;
         r_y     <= '0;
         r_ymax  <= '0;
         r_row   <= '0;
         r_addr  <= '0;
         r_color <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE:
               if (cmd_valid && r_ready) begin
                  r_xmin  <= cmd_x0;
                  r_xmax  <= cmd_x1;
                  r_y     <= cmd_y0;
                  r_ymax  <= cmd_y1;
                  r_color <= cmd_color;
                  r_ready <= 1'b0;
                  r_state <= SETUP;
               end else r_ready <= 1'b1;
            SETUP: begin
               r_err   <= w_drop;
               r_ready <= w_drop;
               r_state <= w_drop ? IDLE : PULSE;
               r_xmin  <= w_xlo;
               r_xmax  <= w_xhi;
               r_x     <= w_xlo;
               r_y     <= w_ylo;
               r_ymax  <= w_yhi;
               r_row   <= w_row;
               r_addr  <= w_row + VGA_ADDR_W'(w_xlo);
            end
            PULSE: r_state <= GAP;
            GAP:
               if (w_adv) begin
                  if (r_x < r_xmax) begin
                     r_x     <= r_x + 8'd1;
                     r_addr  <= r_addr + 15'd1;
                     r_state <= PULSE;
                  end else if (r_y < r_ymax) begin
                     r_y     <= r_y + 7'd1;
                     r_x     <= r_xmin;
                     r_row   <= r_row + VGA_ADDR_W'(SCREEN_W);
                     r_addr  <= r_row + VGA_ADDR_W'(SCREEN_W) + VGA_ADDR_W'(r_xmin);
                     r_state <= PULSE;
                  end else begin
                     r_ready <= 1'b1;
                     r_state <= IDLE;
                  end
               end
            default: r_state <= IDLE;
         endcase
      end

   pixel_pacer #(.GAP_CYCLES(GAP_CYCLES)) u_pacer (
      .clk            (clk),
      .rst            (rst),
      .i_pulse        (r_state == PULSE),
      .i_gap          (r_state == GAP),
      .o_write_enable (write_enable),
      .o_advance      (w_adv)
   );

   assign cmd_ready = r_ready;
   assign cmd_err   = r_err;
   assign busy      = r_state != IDLE;
   assign data_addr = r_addr;
   assign data_in   = r_color;
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: pixel-list model of each rectangle checked every cycle against the DUT,
// plus directed literal checks; honours RECT_CLIP_EN like the design.
module tb_rect_fill_engine;
   localparam int GAP = 1;
   logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
   logic [7:0]  cmd_x0 = '0, cmd_x1 = '0;
   logic [6:0]  cmd_y0 = '0, cmd_y1 = '0;
   logic [2:0]  cmd_color = '0;
   logic        cmd_ready, cmd_err, busy, write_enable;
   logic [14:0] data_addr;
   logic [2:0]  data_in;

   rect_fill_engine #(.GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
      .cmd_color(cmd_color), .cmd_err(cmd_err), .busy(busy),
      .data_addr(data_addr), .data_in(data_in), .write_enable(write_enable)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int addr; int col; int cyc;} px_t;
   px_t  exp_q[$];
   px_t  e;
   int   seen_q[$];
   int   n_assert = 0, n_fail = 0;
   int   exp_ready_at = 0, exp_err_at = -1, rise_cyc = -1;
   bit   chk_en = 1'b0;
   logic prev_we = 1'b0, prev_ready = 1'b0;
   logic [14:0] prev_addr = '0;
   logic [2:0]  prev_in = '0;

   task automatic check(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected pixels: every (x,y) of the normalised rectangle, row-major, one per 1+GAP cycles.
   task automatic model(input int x0, input int x1, input int y0, input int y1, input int col, input int c);
      int xl = x0 < x1 ? x0 : x1, xh = x0 < x1 ? x1 : x0;
      int yl = y0 < y1 ? y0 : y1, yh = y0 < y1 ? y1 : y0;
      int n = 0;
      bit drop;
`ifdef RECT_CLIP_EN
      drop = xl >= 160 || yl >= 120;
      if (xh > 159) xh = 159;
      if (yh > 119) yh = 119;
`else
      drop = xh >= 160 || yh >= 120;
`endif
      if (drop) begin
         exp_err_at   = c + 2;
         exp_ready_at = c + 2;
      end else begin
         for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
               exp_q.push_back('{x + y * 160, col, c + 2 + n * (1 + GAP)});
               n++;
            end
         exp_ready_at = c + 2 + n * (1 + GAP);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready", int'(cmd_ready), int'(cyc >= exp_ready_at));
         check("busy", int'(busy), int'(cyc < exp_ready_at));
         check("err", int'(cmd_err), int'(cyc == exp_err_at));
         if (write_enable) begin
            if (exp_q.size() == 0) check("extra_pulse_addr", int'(data_addr), -1);
            else begin
               e = exp_q.pop_front();
               check("pix_addr", int'(data_addr), e.addr);
               check("pix_color", int'(data_in), e.col);
               check("pix_cycle", cyc, e.cyc);
            end
            seen_q.push_back(int'(data_addr));
         end
         if (prev_we) begin
            check("gap_low", int'(write_enable), 0);
            check("addr_hold", int'(data_addr), int'(prev_addr));
            check("color_hold", int'(data_in), int'(prev_in));
         end
         if (cmd_ready && !prev_ready) rise_cyc = cyc;
      end
      prev_we    = write_enable;
      prev_ready = cmd_ready;
      prev_addr  = data_addr;
      prev_in    = data_in;
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic send(input int x0, input int x1, input int y0, input int y1, input int col, output int c);
      int b = 0;
      while (!cmd_ready && b < 50000) begin tick; b++; end
      check("ready_timeout", int'(cmd_ready), 1);
      cmd_x0 = 8'(x0); cmd_x1 = 8'(x1); cmd_y0 = 7'(y0); cmd_y1 = 7'(y1);
      cmd_color = 3'(col);
      cmd_valid = 1'b1;
      c = cyc;
      model(x0, x1, y0, y1, col, c);
      tick;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle;
      int b = 0;
      while ((exp_q.size() != 0 || !cmd_ready) && b < 50000) begin tick; b++; end
      check("idle_timeout", exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int exp_a[4];
      tick;
      check("rst_ready", int'(cmd_ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_we", int'(write_enable), 0);
      check("rst_addr", int'(data_addr), 0);
      check("rst_data", int'(data_in), 0);
      check("rst_err", int'(cmd_err), 0);
      rst = 1'b0;
      tick;
      check("ready_after_rst", int'(cmd_ready), 1);
      exp_ready_at = cyc;
      chk_en = 1'b1;

      seen_q.delete();
      send(0, 0, 0, 0, 5, c);
      check("single_busy", int'(busy), 1);
      tick;
      check("single_we", int'(write_enable), 1);
      check("single_addr", int'(data_addr), 0);
      check("single_color", int'(data_in), 5);
      tick;
      check("single_ready_c3", int'(cmd_ready), 0);
      tick;
      check("single_ready_c4", int'(cmd_ready), 1);
      wait_idle;
      check("single_count", seen_q.size(), 1);

      seen_q.delete();
      send(158, 159, 118, 119, 3, c);
      wait_idle;
      exp_a = '{19038, 19039, 19198, 19199};
      check("corner_count", seen_q.size(), 4);
      for (int i = 0; i < 4 && i < seen_q.size(); i++) check("corner_addr", seen_q[i], exp_a[i]);

      seen_q.delete();
      send(10, 8, 5, 5, 2, c);
      wait_idle;
      exp_a = '{808, 809, 810, 0};
      check("swap_count", seen_q.size(), 3);
      for (int i = 0; i < 3 && i < seen_q.size(); i++) check("swap_addr", seen_q[i], exp_a[i]);

      seen_q.delete();
      send(150, 200, 0, 0, 6, c);
      tick;
`ifdef RECT_CLIP_EN
      check("oor_err", int'(cmd_err), 0);
      wait_idle;
      check("oor_count", seen_q.size(), 10);
      if (seen_q.size() == 10) begin
         check("oor_first", seen_q[0], 150);
         check("oor_last", seen_q[9], 159);
      end
`else
      check("oor_err", int'(cmd_err), 1);
      check("oor_ready", int'(cmd_ready), 1);
      wait_idle;
      check("oor_count", seen_q.size(), 0);
`endif

      seen_q.delete();
      send(0, 159, 0, 119, 1, c);
      cmd_x0 = 8'd5; cmd_x1 = 8'd6; cmd_y0 = 7'd7; cmd_y1 = 7'd8; cmd_color = 3'd4;
      for (int i = 0; i < 100; i++) begin
         cmd_valid = 1'b1;
         tick;
      end
      cmd_valid = 1'b0;
      wait_idle;
      check("full_count", seen_q.size(), 19200);
      if (seen_q.size() > 0) check("full_last", seen_q[$], 19199);
      check("full_ready_cycle", rise_cyc, c + 38402);

      seen_q.delete();
      send(0, 159, 0, 119, 7, c);
      while (cyc < c + 76) tick;
      check("mid_count", seen_q.size(), 38);
      if (seen_q.size() > 0) check("mid_pixel37", seen_q[$], 37);
      chk_en = 1'b0;
      rst = 1'b1;
      tick;
      check("mid_rst_we", int'(write_enable), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_addr", int'(data_addr), 0);
      check("mid_rst_ready", int'(cmd_ready), 0);
      rst = 1'b0;
      tick;
      check("mid_rel_ready", int'(cmd_ready), 1);
      check("mid_rel_we", int'(write_enable), 0);
      exp_q.delete();
      exp_ready_at = cyc;
      exp_err_at = -1;
      chk_en = 1'b1;

      seen_q.delete();
      send(1, 1, 1, 1, 4, c);
      wait_idle;
      check("post_rst_count", seen_q.size(), 1);
      if (seen_q.size() > 0) check("post_rst_addr", seen_q[0], 161);
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
